id_ex_issue: RTL and testbench
==============================

ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 Parameter MUL_CYCLES, default 32: number of cycles a MULTU occupies EX; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_ALUOp  input  2  decoded ALUOp.
REQ-006 id_funct  input  6  instruction funct field.
REQ-007 id_shamt  input  5  shift amount.
REQ-008 id_dataA / id_dataB  input  32 each  register operands.
REQ-009 id_rd  input  5  destination register; id_RegWrite  input  1  write-back enable.
REQ-010 flush  input  1  kill the instruction entering EX (branch taken).
REQ-011 ALUOp, funct, shamt, dataA, dataB  output  2/6/5/32/32  registered EX operands driving the ALU stage.
REQ-012 ex_rd  output  5; ex_RegWrite  output  1; ex_valid  output  1: registered EX control.
REQ-013 stall  output  1  combinational; holds PC and IF/ID when high.
REQ-014 mul_busy  output  1  high while state is BUSY.

Function
REQ-015 R-type = id_ALUOp 2'b10; MULTU = R-type with funct 6'b011001; MFHI/MFLO = R-type with funct 6'b010000 / 6'b010010; classification applies only when id_valid=1.
REQ-016 States: IDLE, BUSY, HILO_WAIT; 8-bit down-counter cnt.
REQ-017 Bubble = all EX outputs 0 (ALUOp 00, funct 0, shamt 0, data 0, ex_rd 0, ex_RegWrite 0, ex_valid 0).
REQ-018 IDLE, no flush: EX register loads ID fields every edge (id_valid=0 loads bubble); stall=0.
REQ-019 IDLE, MULTU loaded: next state BUSY, cnt=MUL_CYCLES-1.
REQ-020 BUSY, cnt>0: stall=1, EX outputs held unchanged, cnt decrements each edge.
REQ-021 BUSY, cnt=0 (final MULTU cycle): stall=1 and EX loads bubble if incoming is MULTU/MFHI/MFLO, else stall=0 and EX loads ID; next state HILO_WAIT.
REQ-022 HILO_WAIT (one cycle): incoming MFHI/MFLO -> stall=1, EX loads bubble; incoming MULTU -> loaded, next state BUSY per REQ-019; other -> loaded; next state IDLE unless MULTU loaded.
REQ-023 MULTU therefore occupies EX exactly MUL_CYCLES consecutive cycles; MUL_CYCLES=1 enters BUSY with cnt=0.
REQ-024 ex_RegWrite forced 0 for a loaded MULTU; all other fields passed unmodified.
REQ-025 flush in IDLE/HILO_WAIT, or in BUSY with cnt=0: EX loads bubble instead of ID, state transitions as if a bubble were loaded, stall=0.
REQ-026 flush in BUSY with cnt>0: no effect; MULTU is never aborted.
REQ-027 stall never asserted in IDLE.
REQ-028 Operands/funct stay bit-stable through all MUL_CYCLES cycles of a MULTU.

Reset
REQ-029 reset high at an edge: state IDLE, cnt 0, all EX outputs bubble; stall=0, mul_busy=0 from that edge.
REQ-030 reset overrides every other input, including mid-BUSY; the in-flight MULTU is discarded.

Verification (MUL_CYCLES=4)
REQ-031 ADD (funct 32, dataA 5, dataB 7, rd 3) in IDLE -> next cycle ALUOp 10, funct 32, dataA 5, dataB 7, ex_rd 3, ex_RegWrite 1, stall 0.
REQ-032 MULTU (A=0x10, B=0x20) then ADD -> MULTU on EX outputs 4 cycles, stall=1 for cycles 1-3 only, mul_busy=1 cycles 1-4, ADD in EX at cycle 5.
REQ-033 MULTU then MFHI -> stall=1 cycles 1-5, bubble in EX cycles 5-6, MFHI in EX at cycle 7.
REQ-034 flush asserted during BUSY cycle 2 -> EX outputs unchanged, MULTU completes; flush with ADD in IDLE -> bubble in EX.
REQ-035 reset at BUSY cycle 2 -> next cycle state IDLE, all EX outputs 0, stall 0, mul_busy 0.
REQ-036 MULTU then MULTU -> second MULTU waits in ID, bubble in EX cycle 5, second MULTU enters EX cycle 6, mul_busy stays 1 there.

Source files
------------

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with multi-cycle MULTU issue control.
// Holds a MULTU in EX for MUL_CYCLES cycles and keeps HI/LO readers out of the hand-off cycles.
module id_ex_issue #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  id_ALUOp,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_shamt,
  input  logic [31:0] id_dataA,
  input  logic [31:0] id_dataB,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        flush,
  output logic [1:0]  ALUOp,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_valid,
  output logic        stall,
  output logic        mul_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    HILO_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(MUL_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       stall_s;
  logic       load_s;
  logic       bubble_s;
  logic       is_rtype_s;
  logic       is_mult_s;
  logic       is_hilo_s;

  assign is_rtype_s = id_valid && (id_ALUOp == 2'b10);
  assign is_mult_s  = is_rtype_s && (id_funct == 6'b011001);
  assign is_hilo_s  = is_rtype_s && ((id_funct == 6'b010000) || (id_funct == 6'b010010));

  // Next-state, counter and EX load/hold/bubble selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    load_s      = 1'b0;
    bubble_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          bubble_s = 1'b1;
        end else begin
          load_s = 1'b1;
          if (is_mult_s) begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      BUSY: begin
        if (cnt_r != 8'd0) begin
          // An in-flight MULTU ignores flush and keeps EX frozen.
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - 8'd1;
        end else begin
          state_nxt_s = HILO_WAIT;
          cnt_nxt_s   = 8'd0;
          if (flush) begin
            bubble_s = 1'b1;
          end else if (is_mult_s || is_hilo_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
          end else begin
            load_s = 1'b1;
          end
        end
      end
      HILO_WAIT: begin
        state_nxt_s = IDLE;
        if (flush) begin
          bubble_s = 1'b1;
        end else if (is_hilo_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          load_s = 1'b1;
          if (is_mult_s) begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
        bubble_s    = 1'b1;
      end
    endcase
  end

  // State, counter and EX operand register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      ALUOp       <= 2'b00;
      funct       <= 6'd0;
      shamt       <= 5'd0;
      dataA       <= 32'd0;
      dataB       <= 32'd0;
      ex_rd       <= 5'd0;
      ex_RegWrite <= 1'b0;
      ex_valid    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (bubble_s || (load_s && !id_valid)) begin
        ALUOp       <= 2'b00;
        funct       <= 6'd0;
        shamt       <= 5'd0;
        dataA       <= 32'd0;
        dataB       <= 32'd0;
        ex_rd       <= 5'd0;
        ex_RegWrite <= 1'b0;
        ex_valid    <= 1'b0;
      end else if (load_s) begin
        ALUOp       <= id_ALUOp;
        funct       <= id_funct;
        shamt       <= id_shamt;
        dataA       <= id_dataA;
        dataB       <= id_dataB;
        ex_rd       <= id_rd;
        // MULTU writes HI/LO, never the register file.
        ex_RegWrite <= id_RegWrite & ~is_mult_s;
        ex_valid    <= 1'b1;
      end
    end
  end

  assign stall    = stall_s;
  assign mul_busy = (state_r == BUSY);

endmodule

// File: tb/tb_id_ex_issue.sv
// Table-driven bench for id_ex_issue with MUL_CYCLES=4, plus hand-written
// reset and MULTU-duration sequences.
module tb_id_ex_issue;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
  } instr_t;

  typedef struct {
    logic   rst;
    logic   flush;
    instr_t id;
    logic   exp_stall;
    instr_t exp_ex;
    logic   exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_ALUOp;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [31:0] id_dataA;
  logic [31:0] id_dataB;
  logic [4:0]  id_rd;
  logic        id_RegWrite;
  logic        flush;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_valid;
  logic        stall;
  logic        mul_busy;

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs[$];

  id_ex_issue #(.MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUOp(id_ALUOp),
    .id_funct(id_funct), .id_shamt(id_shamt), .id_dataA(id_dataA),
    .id_dataB(id_dataB), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
    .flush(flush), .ALUOp(ALUOp), .funct(funct), .shamt(shamt),
    .dataA(dataA), .dataB(dataB), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .ex_valid(ex_valid), .stall(stall), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  localparam instr_t NOP   = '0;
  localparam instr_t ADD   = '{1'b1, 2'b10, 6'd32, 5'd0, 32'd5, 32'd7, 5'd3, 1'b1};
  localparam instr_t SUB   = '{1'b1, 2'b10, 6'd34, 5'd3, 32'hFFFF_FFFF, 32'd1, 5'd31, 1'b1};
  localparam instr_t ITYP  = '{1'b1, 2'b00, 6'd25, 5'd2, 32'h100, 32'hABCD, 5'd9, 1'b1};
  localparam instr_t INV   = '{1'b0, 2'b10, 6'd25, 5'd1, 32'h55, 32'h66, 5'd7, 1'b1};
  localparam instr_t MUL   = '{1'b1, 2'b10, 6'd25, 5'd0, 32'h10, 32'h20, 5'd4, 1'b1};
  localparam instr_t MUL_X = '{1'b1, 2'b10, 6'd25, 5'd0, 32'h10, 32'h20, 5'd4, 1'b0};
  localparam instr_t MFHI  = '{1'b1, 2'b10, 6'd16, 5'd0, 32'd0, 32'd0, 5'd8, 1'b1};
  localparam instr_t MFLO  = '{1'b1, 2'b10, 6'd18, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1};

  task automatic add(input logic r, input logic f, input instr_t id,
                     input logic s, input instr_t ex, input logic b);
    vec_t v;
    v.rst = r; v.flush = f; v.id = id;
    v.exp_stall = s; v.exp_ex = ex; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input instr_t id);
    reset = r; flush = f;
    id_valid = id.valid; id_ALUOp = id.aluop; id_funct = id.funct;
    id_shamt = id.shamt; id_dataA = id.a; id_dataB = id.b;
    id_rd = id.rd; id_RegWrite = id.rw;
  endtask

  function automatic instr_t ex_now();
    return '{ex_valid, ALUOp, funct, shamt, dataA, dataB, ex_rd, ex_RegWrite};
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    // Reset state.
    drive(1'b1, 1'b0, NOP);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex", -1, 128'(ex_now()), 128'(NOP));
    chk("reset_stall", -1, 128'(stall), 128'(1'b0));
    chk("reset_busy", -1, 128'(mul_busy), 128'(1'b0));

    // rst flush  ID    stall EX-after-edge busy
    add(0, 0, ADD,  0, ADD,   0);
    add(0, 0, ITYP, 0, ITYP,  0);
    add(0, 0, SUB,  0, SUB,   0);
    add(0, 0, INV,  0, NOP,   0);
    // MULTU then ADD
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  0, ADD,   0);
    add(0, 0, NOP,  0, NOP,   0);
    // MULTU then MFHI
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, MFHI, 1, MUL_X, 1);
    add(0, 0, MFHI, 1, MUL_X, 1);
    add(0, 0, MFHI, 1, MUL_X, 1);
    add(0, 0, MFHI, 1, NOP,   0);
    add(0, 0, MFHI, 1, NOP,   0);
    add(0, 0, MFHI, 0, MFHI,  0);
    add(0, 0, NOP,  0, NOP,   0);
    // MULTU then MULTU, then flush at final cycle and in HILO_WAIT
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, MUL,  1, MUL_X, 1);
    add(0, 0, MUL,  1, MUL_X, 1);
    add(0, 0, MUL,  1, MUL_X, 1);
    add(0, 0, MUL,  1, NOP,   0);
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 1, ADD,  0, NOP,   0);
    add(0, 1, MFLO, 0, NOP,   0);
    // flush mid-BUSY is ignored; flush in IDLE gives a bubble
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 1, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(0, 0, ADD,  0, ADD,   0);
    add(0, 0, SUB,  0, SUB,   0);
    add(0, 1, ADD,  0, NOP,   0);
    // reset in BUSY discards the MULTU
    add(0, 0, MUL,  0, MUL_X, 1);
    add(0, 0, ADD,  1, MUL_X, 1);
    add(1, 0, ADD,  1, NOP,   0);
    add(0, 0, ADD,  0, ADD,   0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].id);
      #2;
      chk("stall", i, 128'(stall), 128'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      chk("ex_regs", i, 128'(ex_now()), 128'(vecs[i].exp_ex));
      chk("mul_busy", i, 128'(mul_busy), 128'(vecs[i].exp_busy));
    end

    // MULTU must occupy BUSY for exactly four cycles; bounded wait.
    drive(1'b0, 1'b0, MUL);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, NOP);
    n = 0;
    while (mul_busy && n < 20) begin
      n++;
      if (ex_now() !== MUL_X) begin
        chk("mul_hold", n, 128'(ex_now()), 128'(MUL_X));
      end
      @(posedge clk);
      #1;
    end
    chk("mul_duration", 0, 128'(n), 128'(4));
    chk("after_mul_ex", 0, 128'(ex_now()), 128'(NOP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
